// File: rtl/omem_multichannel_writer_if.sv
// ----------------------------------------------------------------------------
// omem_multichannel_writer_if
//   Wishbone single-word write bus between the output-memory writer (master)
//   and the shared external output-memory bus (slave).
//
//   ADR_O  master->slave  word address
//   DAT_O  master->slave  write data
//   WE_O   master->slave  write enable (mirrors STB_O)
//   STB_O  master->slave  strobe, a word is offered while high
//   CYC_O  master->slave  bus request / cycle in progress
//   GNT_I  slave->master  bus grant, only looked at while requesting
//   ACK_I  slave->master  word acknowledge
//
//   Handshake: a word transfers on a rising edge where STB_O=1 and ACK_I=1.
//   While STB_O=1 and ACK_I=0 the master holds ADR_O/DAT_O stable; STB_O
//   never drops before its ACK. ACK_I outside a strobe is ignored.
// ----------------------------------------------------------------------------
interface omem_multichannel_writer_if #(
    parameter int WB_WIDTH = 32
);
    logic [WB_WIDTH-1:0] ADR_O;
    logic [WB_WIDTH-1:0] DAT_O;
    logic                WE_O;
    logic                STB_O;
    logic                CYC_O;
    logic                GNT_I;
    logic                ACK_I;

    modport master (
        output ADR_O, DAT_O, WE_O, STB_O, CYC_O,
        input  GNT_I, ACK_I
    );

    modport slave (
        input  ADR_O, DAT_O, WE_O, STB_O, CYC_O,
        output GNT_I, ACK_I
    );
endinterface

// File: rtl/omem_multichannel_writer.sv
// ----------------------------------------------------------------------------
// omem_multichannel_writer
//   Collects full-row write requests from NUM_CH producers into per-channel
//   FIFOs and serialises each row, round-robin between channels, into
//   WORDS_PER_ROW single-word Wishbone writes. Rows are never interleaved.
//
//   CLK_I         clock, rising edge
//   RST_I         synchronous active-low reset
//   iWriteEnable  per-channel row push request (accepted only when !oFull)
//   iAddress      per-channel row base word address, channel c at slice c
//   iData         per-channel row data, word k at bits [k*WB_WIDTH +: WB_WIDTH]
//   oFull         per-channel FIFO full
//   oOverflow     per-channel sticky "request arrived while full"
//   oIdle         every FIFO empty and the sequencer idle
//   oDebugState   sequencer state (0 idle, 1 bus request, 2 transfer)
//   wb            Wishbone master bus (see omem_multichannel_writer_if)
// ----------------------------------------------------------------------------
module omem_multichannel_writer #(
    parameter int NUM_CH        = 4,
    parameter int WB_WIDTH      = 32,
    parameter int WORDS_PER_ROW = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                   CLK_I,
    input  logic                                   RST_I,
    input  logic [NUM_CH-1:0]                      iWriteEnable,
    input  logic [NUM_CH*WB_WIDTH-1:0]             iAddress,
    input  logic [NUM_CH*WORDS_PER_ROW*WB_WIDTH-1:0] iData,
    output logic [NUM_CH-1:0]                      oFull,
    output logic [NUM_CH-1:0]                      oOverflow,
    output logic                                   oIdle,
    output logic [1:0]                             oDebugState,
    omem_multichannel_writer_if.master             wb
);
    localparam int ROW_W = WORDS_PER_ROW * WB_WIDTH;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int K_W   = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    // Channel FIFOs
    logic [WB_WIDTH-1:0] r_fifo_adr [NUM_CH][FIFO_DEPTH];
    logic [ROW_W-1:0]    r_fifo_dat [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr     [NUM_CH];
    logic [PTR_W-1:0]    r_rptr     [NUM_CH];
    logic [CNT_W-1:0]    r_count    [NUM_CH];
    logic [NUM_CH-1:0]   r_overflow;

    // Sequencer
    state_t              r_state;
    logic [CH_W-1:0]     r_rr;
    logic [CH_W-1:0]     r_sel;
    logic [K_W-1:0]      r_k;
    logic [WB_WIDTH-1:0] r_base;
    logic [ROW_W-1:0]    r_row;
    logic [WB_WIDTH-1:0] r_adr;
    logic [WB_WIDTH-1:0] r_dat;
    logic                r_stb;
    logic                r_cyc;

    logic [NUM_CH-1:0]   w_full;
    logic [NUM_CH-1:0]   w_nonempty;
    logic [NUM_CH-1:0]   w_push;
    logic [NUM_CH-1:0]   w_pop;
    logic                w_last_word;
    logic                w_found;
    logic [CH_W-1:0]     w_pick;

    assign w_last_word = (r_k == K_W'(WORDS_PER_ROW - 1));

    // Full is judged on the registered count only, so a pop on the same
    // edge never lets a push into a full FIFO.
    always_comb begin
        w_full     = '0;
        w_nonempty = '0;
        w_push     = '0;
        w_pop      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_full[c]     = (r_count[c] == CNT_W'(FIFO_DEPTH));
            w_nonempty[c] = (r_count[c] != '0);
            w_push[c]     = iWriteEnable[c] && !w_full[c];
            w_pop[c]      = (r_state == ST_XFER) && wb.ACK_I && w_last_word
                            && (r_sel == CH_W'(c));
        end
    end

    // Round-robin pick: first non-empty channel at or after r_rr, wrapping.
    always_comb begin : pick_blk
        int idx;
        w_found = 1'b0;
        w_pick  = r_rr;
        idx     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(r_rr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!w_found && w_nonempty[CH_W'(idx)]) begin
                w_found = 1'b1;
                w_pick  = CH_W'(idx);
            end
        end
    end

    // FIFO storage carries no reset; validity lives in the pointers/counts.
    always_ff @(posedge CLK_I) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_push[c]) begin
                r_fifo_adr[c][r_wptr[c]] <= iAddress[c*WB_WIDTH +: WB_WIDTH];
                r_fifo_dat[c][r_wptr[c]] <= iData[c*ROW_W +: ROW_W];
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_wptr[c]  <= '0;
                r_rptr[c]  <= '0;
                r_count[c] <= '0;
            end
            r_overflow <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_push[c]) r_wptr[c] <= r_wptr[c] + PTR_W'(1);
                if (w_pop[c])  r_rptr[c] <= r_rptr[c] + PTR_W'(1);
                if (w_push[c] && !w_pop[c])
                    r_count[c] <= r_count[c] + CNT_W'(1);
                else if (!w_push[c] && w_pop[c])
                    r_count[c] <= r_count[c] - CNT_W'(1);
                if (iWriteEnable[c] && w_full[c]) r_overflow[c] <= 1'b1;
            end
        end
    end

    // The head entry stays in its FIFO until the last word is acknowledged;
    // the latched copy in r_base/r_row drives the bus meanwhile.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            r_state <= ST_IDLE;
            r_rr    <= '0;
            r_sel   <= '0;
            r_k     <= '0;
            r_base  <= '0;
            r_row   <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_stb   <= 1'b0;
            r_cyc   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_sel   <= w_pick;
                        r_base  <= r_fifo_adr[w_pick][r_rptr[w_pick]];
                        r_row   <= r_fifo_dat[w_pick][r_rptr[w_pick]];
                        r_k     <= '0;
                        r_cyc   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (wb.GNT_I) begin
                        r_stb   <= 1'b1;
                        r_adr   <= r_base;
                        r_dat   <= r_row[WB_WIDTH-1:0];
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (wb.ACK_I) begin
                        if (!w_last_word) begin
                            r_k   <= r_k + K_W'(1);
                            r_adr <= r_base + WB_WIDTH'(r_k) + WB_WIDTH'(1);
                            r_dat <= r_row[(int'(r_k) + 1)*WB_WIDTH +: WB_WIDTH];
                        end else begin
                            r_stb   <= 1'b0;
                            r_cyc   <= 1'b0;
                            r_adr   <= '0;
                            r_dat   <= '0;
                            r_rr    <= (r_sel == CH_W'(NUM_CH - 1)) ? '0
                                                                   : r_sel + CH_W'(1);
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign oFull       = w_full;
    assign oOverflow   = r_overflow;
    assign oIdle       = (r_state == ST_IDLE) && (w_nonempty == '0);
    assign oDebugState = r_state;
    assign wb.ADR_O    = r_adr;
    assign wb.DAT_O    = r_dat;
    assign wb.STB_O    = r_stb;
    assign wb.WE_O     = r_stb;
    assign wb.CYC_O    = r_cyc;
endmodule

// File: tb/tb_omem_multichannel_writer.sv
module tb_omem_multichannel_writer;
    localparam int NUM_CH = 4;
    localparam int W      = 32;
    localparam int WPR    = 3;
    localparam int DEPTH  = 4;
    localparam int ROW_W  = WPR * W;

    // ---------------- clock / reset / DUT ----------------
    logic                    CLK_I = 1'b0;
    logic                    RST_I = 1'b0;
    logic [NUM_CH-1:0]       iWriteEnable = '0;
    logic [NUM_CH*W-1:0]     iAddress = '0;
    logic [NUM_CH*ROW_W-1:0] iData = '0;
    logic [NUM_CH-1:0]       oFull;
    logic [NUM_CH-1:0]       oOverflow;
    logic                    oIdle;
    logic [1:0]              oDebugState;

    omem_multichannel_writer_if #(.WB_WIDTH(W)) bus ();

    omem_multichannel_writer #(
        .NUM_CH(NUM_CH), .WB_WIDTH(W), .WORDS_PER_ROW(WPR), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .iWriteEnable(iWriteEnable),
        .iAddress(iAddress), .iData(iData), .oFull(oFull),
        .oOverflow(oOverflow), .oIdle(oIdle), .oDebugState(oDebugState),
        .wb(bus)
    );

    always #5 CLK_I = ~CLK_I;

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int             ch;
        logic [W-1:0]     base;
        logic [ROW_W-1:0] data;
    } row_t;

    typedef struct {
        logic [NUM_CH-1:0] we;
        logic              gnt;
        logic              ack;
        logic              cyc;
        logic              stb;
        logic [W-1:0]      adr;
        logic [W-1:0]      dat;
        logic              idle;
    } vec_t;

    row_t              exp_q[$];
    int                row_order[$];
    logic [W-1:0]      adr_log[$];
    int                pending[NUM_CH];
    logic [NUM_CH-1:0] ovf_m = '0;
    row_t              cur;
    bit                cur_ok = 0;
    bit                row_open = 0;
    int                mon_k = 0;
    int                stb_cycles = 0;

    logic [W-1:0]      pa[NUM_CH];
    logic [ROW_W-1:0]  pd[NUM_CH];
    int                ack_mode = 0;   // 0: fixed wait states, 1: random, 2: forced
    int                ack_wait = 0;
    int                wait_cnt = 0;
    logic              ack_force = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic rand_row(input int c);
        pa[c] = $urandom;
        for (int w = 0; w < WPR; w++) pd[c][w*W +: W] = $urandom;
    endtask

    // One clock cycle: at the falling edge pick ACK for the coming edge,
    // check outputs against the model, drive the pushes, update the model.
    task automatic step(input logic [NUM_CH-1:0] we);
        logic [NUM_CH-1:0] full_m;
        bit                seen[NUM_CH];
        int                done_ch;
        done_ch = -1;
        @(negedge CLK_I);
        case (ack_mode)
            0: begin
                if (bus.STB_O) begin
                    if (wait_cnt >= ack_wait) begin bus.ACK_I = 1'b1; wait_cnt = 0; end
                    else begin bus.ACK_I = 1'b0; wait_cnt++; end
                end else begin
                    bus.ACK_I = 1'b0;
                    wait_cnt  = 0;
                end
            end
            1:       bus.ACK_I = 1'($urandom_range(0, 1));
            default: bus.ACK_I = ack_force;
        endcase

        for (int c = 0; c < NUM_CH; c++) full_m[c] = (pending[c] == DEPTH);
        chk("oFull", W'(oFull), W'(full_m));
        chk("oOverflow", W'(oOverflow), W'(ovf_m));

        if (bus.STB_O) begin
            stb_cycles++;
            if (!row_open) begin
                foreach (seen[j]) seen[j] = 0;
                cur_ok   = 0;
                row_open = 1;
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (!seen[exp_q[i].ch]) begin
                        seen[exp_q[i].ch] = 1;
                        if (exp_q[i].base == bus.ADR_O && exp_q[i].data[W-1:0] == bus.DAT_O) begin
                            cur    = exp_q[i];
                            cur_ok = 1;
                            exp_q.delete(i);
                            break;
                        end
                    end
                end
                n_vec++;
                if (!cur_ok) begin
                    n_err++;
                    $display("FAIL row_start: adr 0x%08h dat 0x%08h, required a queued channel head", bus.ADR_O, bus.DAT_O);
                end else begin
                    row_order.push_back(cur.ch);
                end
            end
            if (cur_ok) begin
                chk("bus_adr", bus.ADR_O, cur.base + W'(mon_k));
                chk("bus_dat", bus.DAT_O, cur.data[mon_k*W +: W]);
            end
            if (bus.ACK_I) begin
                adr_log.push_back(bus.ADR_O);
                mon_k++;
                if (mon_k == WPR) begin
                    mon_k    = 0;
                    row_open = 0;
                    if (cur_ok) done_ch = cur.ch;
                end
            end
        end

        iWriteEnable = we;
        for (int c = 0; c < NUM_CH; c++) begin
            iAddress[c*W +: W]      = pa[c];
            iData[c*ROW_W +: ROW_W] = pd[c];
            if (we[c]) begin
                if (pending[c] < DEPTH) begin
                    exp_q.push_back('{c, pa[c], pd[c]});
                    pending[c]++;
                end else begin
                    ovf_m[c] = 1'b1;
                end
            end
        end
        if (done_ch >= 0) pending[done_ch]--;
    endtask

    task automatic do_reset();
        @(negedge CLK_I);
        RST_I        = 1'b0;
        iWriteEnable = '0;
        bus.ACK_I    = 1'b0;
        @(posedge CLK_I);
        #2;
        chk("rst_cyc", W'(bus.CYC_O), 0);
        chk("rst_stb", W'(bus.STB_O), 0);
        chk("rst_we", W'(bus.WE_O), 0);
        chk("rst_adr", bus.ADR_O, 0);
        chk("rst_dat", bus.DAT_O, 0);
        chk("rst_idle", W'(oIdle), 1);
        chk("rst_full", W'(oFull), 0);
        chk("rst_ovf", W'(oOverflow), 0);
        @(negedge CLK_I);
        RST_I = 1'b1;
        exp_q.delete();
        foreach (pending[c]) pending[c] = 0;
        ovf_m    = '0;
        mon_k    = 0;
        row_open = 0;
        wait_cnt = 0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && !(oIdle && exp_q.size() == 0); i++) step('0);
        chk(name, W'(oIdle && exp_q.size() == 0), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (pending[c]) pending[c] = 0;
        foreach (pa[c]) begin pa[c] = '0; pd[c] = '0; end
        bus.GNT_I = 1'b0;
        bus.ACK_I = 1'b0;

        // Cycle-exact vectors: one row on ch1, grant and ack tied high.
        //          we       gnt   ack   cyc   stb   adr        dat     idle
        tbl[0] = '{4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0, 1'b0};
        tbl[1] = '{4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,     32'h0, 1'b0};
        tbl[2] = '{4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100,   32'hA, 1'b0};
        tbl[3] = '{4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 32'h101,   32'hB, 1'b0};
        tbl[4] = '{4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 32'h102,   32'hC, 1'b0};
        tbl[5] = '{4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0, 1'b1};
        tbl[6] = '{4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0, 1'b1};

        do_reset();

        // ---- single row, exact timing ----
        pa[1] = 32'h100;
        pd[1] = {32'hC, 32'hB, 32'hA};
        ack_mode = 2;
        foreach (tbl[i]) begin
            bus.GNT_I = tbl[i].gnt;
            ack_force = tbl[i].ack;
            step(tbl[i].we);
            @(posedge CLK_I);
            #2;
            chk("t1_cyc", W'(bus.CYC_O), W'(tbl[i].cyc));
            chk("t1_stb", W'(bus.STB_O), W'(tbl[i].stb));
            chk("t1_we", W'(bus.WE_O), W'(tbl[i].stb));
            chk("t1_adr", bus.ADR_O, tbl[i].adr);
            chk("t1_dat", bus.DAT_O, tbl[i].dat);
            chk("t1_idle", W'(oIdle), W'(tbl[i].idle));
        end

        // ---- round-robin order 0,2,3 then late ch0 ----
        do_reset();
        ack_mode = 0; ack_wait = 0; bus.GNT_I = 1'b1;
        row_order.delete(); adr_log.delete();
        rand_row(0); rand_row(2); rand_row(3);
        step(4'b1101);
        for (int i = 0; i < 100 && adr_log.size() < WPR + 1; i++) step('0);
        chk("t2_ch2_started", W'(adr_log.size() >= WPR + 1), 1);
        rand_row(0);
        step(4'b0001);
        drain("t2_drain");
        chk("t2_rows", W'(row_order.size()), 4);
        if (row_order.size() == 4) begin
            chk("t2_order0", W'(row_order[0]), 0);
            chk("t2_order1", W'(row_order[1]), 2);
            chk("t2_order2", W'(row_order[2]), 3);
            chk("t2_order3", W'(row_order[3]), 0);
        end

        // ---- overflow with grant withheld ----
        bus.GNT_I = 1'b0;
        for (int p = 0; p < 5; p++) begin
            rand_row(0);
            step(4'b0001);
            if (p == 4) begin
                chk("t3_full_after4", W'(oFull[0]), 1);
                chk("t3_noovf_yet", W'(oOverflow[0]), 0);
            end
        end
        step('0);
        chk("t3_ovf", W'(oOverflow[0]), 1);
        row_order.delete();
        bus.GNT_I = 1'b1;
        drain("t3_drain");
        chk("t3_rows", W'(row_order.size()), 4);
        chk("t3_ovf_sticky", W'(oOverflow[0]), 1);

        // ---- two ack wait states per word ----
        ack_wait = 2; stb_cycles = 0; adr_log.delete();
        rand_row(2);
        step(4'b0100);
        drain("t4_drain");
        chk("t4_stb_cycles", W'(stb_cycles), 9);
        chk("t4_words", W'(adr_log.size()), 3);

        // ---- address wrap ----
        ack_wait = 0; adr_log.delete();
        rand_row(3);
        pa[3] = 32'hFFFF_FFFF;
        step(4'b1000);
        drain("t5_drain");
        chk("t5_words", W'(adr_log.size()), 3);
        if (adr_log.size() == 3) begin
            chk("t5_adr0", adr_log[0], 32'hFFFF_FFFF);
            chk("t5_adr1", adr_log[1], 32'h0000_0000);
            chk("t5_adr2", adr_log[2], 32'h0000_0001);
        end

        // ---- reset mid-row with two rows queued ----
        ack_mode = 2; ack_force = 1'b1; adr_log.delete();
        rand_row(0); rand_row(1);
        step(4'b0011);
        for (int i = 0; i < 50 && adr_log.size() < 1; i++) step('0);
        chk("t6_word0_done", W'(adr_log.size()), 1);
        do_reset();
        stb_cycles = 0;
        for (int i = 0; i < 20; i++) step('0);
        chk("t6_no_writes", W'(stb_cycles), 0);
        chk("t6_idle", W'(oIdle), 1);

        // ---- randomized traffic against the model ----
        do_reset();
        ack_mode = 1;
        for (int n = 0; n < 1500; n++) begin
            logic [NUM_CH-1:0] we;
            bus.GNT_I = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < NUM_CH; c++) begin
                we[c] = ($urandom_range(0, 5) == 0);
                rand_row(c);
            end
            step(we);
        end
        bus.GNT_I = 1'b1;
        ack_mode  = 0;
        ack_wait  = 0;
        drain("rand_drain");
        chk("rand_exp_empty", W'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/omem_multichannel_writer.md
# omem_multichannel_writer

Buffered, parametrised output-memory write interface. It accepts full-row write requests from NUM_CH independent producers and queues them in per-channel FIFOs. A round-robin arbiter serialises each row into WORDS_PER_ROW single-word Wishbone master writes with a proper STB/ACK handshake and bus grant, so that writes are never lost under bus stalls. It sits in the IO unit between the execution cores' OMEM write ports and the shared external output-memory bus.

## Interface
- NUM_CH, 4, number of producer channels (1..8)
- WB_WIDTH, 32, Wishbone data/address width
- WORDS_PER_ROW, 3, bus words per data row; a row is WORDS_PER_ROW*WB_WIDTH bits
- FIFO_DEPTH, 4, entries per channel FIFO (power of 2, >=2)

- CLK_I  in  1  clock; all logic on rising edge
- RST_I  in  1  reset, synchronous, active-low
- iWriteEnable  in  NUM_CH  per-channel row write request
- iAddress  in  NUM_CH*WB_WIDTH  per-channel row base word address; channel c at slice c
- iData  in  NUM_CH*WORDS_PER_ROW*WB_WIDTH  per-channel row data; channel c at slice c
- oFull  out  NUM_CH  channel FIFO full; a request is accepted only when this is low
- oOverflow  out  NUM_CH  sticky: a request arrived while full
- oIdle  out  1  all FIFOs empty and FSM in IDLE
- ADR_O  out  WB_WIDTH  bus word address
- DAT_O  out  WB_WIDTH  bus write data
- WE_O  out  1  write enable; equals STB_O
- STB_O  out  1  strobe
- CYC_O  out  1  cycle/bus request
- GNT_I  in  1  bus grant
- ACK_I  in  1  word acknowledge

## Operation
- Push: at a rising edge with iWriteEnable[c]=1 and oFull[c]=0, {iAddress slice c, iData slice c} is written to FIFO c. With oFull[c]=1 the request is dropped and oOverflow[c] is set; it stays set until reset.
- Push on a full FIFO is rejected even when a pop occurs in the same cycle. oFull is derived from the registered occupancy count.
- FSM states:
  - IDLE: if any FIFO is non-empty, select the first non-empty channel at or after rr_ptr (wrapping modulo NUM_CH), latch its head entry, set word index k=0, go to REQ.
  - REQ: CYC_O=1. When GNT_I=1 at an edge, go to XFER.
  - XFER: CYC_O=STB_O=WE_O=1, ADR_O=base+k (modulo 2^WB_WIDTH), DAT_O=data[(k+1)*WB_WIDTH-1 : k*WB_WIDTH]. On an edge with ACK_I=1:
    - if k<WORDS_PER_ROW-1, increment k and stay in XFER;
    - otherwise pop FIFO sel, set rr_ptr=sel+1 (wrapping), go to IDLE.
- GNT_I is sampled only in REQ; deassertion during XFER is ignored.
- ACK_I outside XFER is ignored.
- Words of a row are always issued in order and contiguously, with no interleaving between channels.
- Reset (RST_I=0 at an edge):
  - FIFOs are emptied, rr_ptr=0, k=0, FSM goes to IDLE, oOverflow is cleared.
  - Reset takes effect mid-transfer; the in-flight row is discarded.

## Timing
- Reset values: STB_O=WE_O=CYC_O=0, ADR_O=DAT_O=0, oFull=0, oOverflow=0, oIdle=1.
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
- Push at edge E0: FIFO non-empty after E0. FSM leaves IDLE at E1, so CYC_O=1 in the cycle after E1.
- GNT_I=1 sampled at edge E2: STB_O=1 with word 0 after E2.
- With zero-wait ACK_I, one word completes per cycle. Minimum row occupancy is 1 (REQ) + WORDS_PER_ROW (XFER) cycles, plus 1 IDLE cycle between rows; CYC_O drops for that cycle.
- The last ACK edge pops the FIFO: oFull[sel] falls and oIdle may rise after that edge.
- ADR_O and DAT_O are held stable while STB_O=1 and ACK_I=0.

## Test plan
1. Single push, NUM_CH=4, ch1 addr 0x100, data words {0xA,0xB,0xC}, GNT_I tied 1, ACK_I tied 1 -> CYC_O after 2 edges; writes 0x100/0xA, 0x101/0xB, 0x102/0xC on consecutive cycles; oIdle=1 afterwards.
2. Simultaneous push on ch0, ch2, ch3 with rr_ptr=0 -> rows served in order 0, 2, 3. A new ch0 push made during ch2's transfer is served after ch3.
3. Five pushes on ch0 while GNT_I=0 (FIFO_DEPTH=4) -> oFull[0]=1 after 4th push; 5th push dropped and oOverflow[0]=1. Release grant -> exactly 4 rows issued; oOverflow[0] stays 1.
4. ACK_I with 2 wait cycles per word -> each word held stable for 3 cycles; no word skipped or repeated.
5. Base address 0xFFFFFFFF, WB_WIDTH=32 -> ADR_O sequence 0xFFFFFFFF, 0x00000000, 0x00000001.
6. RST_I=0 during word 1 of a row with 2 rows queued -> next cycle all bus outputs 0, oIdle=1, oFull=0. No further writes after reset release until a new push.
